// File: rtl/t_pulse_sequencer.sv
// t_pulse_sequencer
// Emits a burst of single-cycle toggle-enable pulses (T) for a downstream
// D-based T flip-flop. Each command gives a pulse count and the number of
// T-low cycles placed between consecutive pulses. A command can be cancelled
// with abort. Completion is reported with a one-cycle done or aborted pulse.
// Every output comes straight from a flop: the output values for the next
// cycle are decoded from the next state and registered with the state.
module t_pulse_sequencer #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             T,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // Increment that sticks at all-ones. The command count already bounds the
  // pulse count, so this only guards against an impossible wrap.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  // Control state and registered outputs
  state_t           r_state;
  logic             r_T;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;
  logic             r_aborted;

  // Per-command working registers
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic [GAP_W-1:0] r_gap_cfg;
  logic [GAP_W-1:0] r_gap_cnt;

  // Combinational decode
  state_t           w_next;
  logic             w_fin_abort;
  logic             w_hs;
  logic             w_last_pulse;
  logic             w_gap_end;
  logic             w_T_d;
  logic             w_busy_d;
  logic             w_ready_d;
  logic             w_done_d;
  logic             w_aborted_d;

  // A command is taken only while idle; anything offered otherwise is dropped.
  assign w_hs         = cmd_valid && (r_state == S_IDLE);
  // The pulse being emitted now is the last one of the command.
  assign w_last_pulse = (r_remaining == CNT_ONE);
  // The gap cycle being spent now is the last one before the next pulse.
  assign w_gap_end    = (r_gap_cnt == GAP_ONE);

  // State register plus output flops; reset beats handshake and abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_T       <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_T       <= w_T_d;
      r_busy    <= w_busy_d;
      r_ready   <= w_ready_d;
      r_done    <= w_done_d;
      r_aborted <= w_aborted_d;
    end
  end

  // Next-state selection; abort in PULSE/GAP outranks the last-pulse exit.
  always_comb begin
    w_next      = r_state;
    w_fin_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          // A zero-length command completes without ever pulsing.
          w_next = (cmd_count == '0) ? S_FIN : S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          w_next      = S_FIN;
          w_fin_abort = 1'b1;
        end else if (w_last_pulse) begin
          w_next = S_FIN;
        end else if (r_gap_cfg == '0) begin
          w_next = S_PULSE;
        end else begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) begin
          w_next      = S_FIN;
          w_fin_abort = 1'b1;
        end else if (w_gap_end) begin
          w_next = S_PULSE;
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    w_T_d       = (w_next == S_PULSE);
    w_busy_d    = (w_next == S_PULSE) || (w_next == S_GAP);
    w_ready_d   = (w_next == S_IDLE);
    w_done_d    = (w_next == S_FIN) && !w_fin_abort;
    w_aborted_d = (w_next == S_FIN) &&  w_fin_abort;
  end

  // Pulse counter: cleared on accept, bumped at the end of every PULSE
  // cycle (including one cut short by abort), held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse_cnt <= '0;
    end else if (w_hs) begin
      r_pulse_cnt <= '0;
    end else if (r_state == S_PULSE) begin
      r_pulse_cnt <= f_sat_inc(r_pulse_cnt);
    end
  end

  // Command latch and pulses-remaining countdown.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_remaining <= cmd_count;
      r_gap_cfg   <= cmd_gap;
    end else if (r_state == S_PULSE) begin
      r_remaining <= r_remaining - CNT_ONE;
    end
  end

  // Gap countdown: armed during each pulse, run down while in GAP.
  always_ff @(posedge clk) begin
    if (r_state == S_PULSE) begin
      r_gap_cnt <= r_gap_cfg;
    end else if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt - GAP_ONE;
    end
  end

  assign cmd_ready = r_ready;
  assign T         = r_T;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_t_pulse_sequencer.sv
// Bench for t_pulse_sequencer: the driver issues commands and pushes the
// expected T timeline and completion record; a monitor consumes them.
module tb_t_pulse_sequencer;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [GAP_W-1:0] cmd_gap = '0;
  logic             cmd_ready;
  logic             T;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pulse_cnt;

  t_pulse_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .cmd_gap   (cmd_gap),
    .abort     (abort),
    .T         (T),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic q = 1'b0;
  bit   mon_en = 1'b0;

  typedef struct {
    bit   ab;
    int   cnt;
    int   fcyc;
    logic qv;
  } fin_t;

  bit   exp_t_q[$];
  fin_t exp_fin_q[$];

  // Edge counter and the downstream T flip-flop (Q toggles when T=1).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (T === 1'b1) q <= ~q;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one timeline entry per busy cycle, one record per completion.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, !(busy || done || aborted)});
      if (busy === 1'b1) begin
        if (exp_t_q.size() == 0) begin
          chk("busy_with_no_expect", {63'd0, busy}, 64'd0);
        end else begin
          chk("T", {63'd0, T}, {63'd0, exp_t_q.pop_front()});
        end
      end else begin
        chk("T_not_busy", {63'd0, T}, 64'd0);
      end
      if (done === 1'b1 || aborted === 1'b1) begin
        if (exp_fin_q.size() == 0) begin
          chk("fin_with_no_expect", {63'd0, done | aborted}, 64'd0);
        end else begin
          fin_t r;
          r = exp_fin_q.pop_front();
          chk("done", {63'd0, done}, {63'd0, !r.ab});
          chk("aborted", {63'd0, aborted}, {63'd0, r.ab});
          chk("pulse_cnt", {56'd0, pulse_cnt}, 64'(r.cnt));
          chk("fin_cycle", 64'(cyc), 64'(r.fcyc));
          chk("tff_q", {63'd0, q}, {63'd0, r.qv});
          chk("timeline_left", 64'(exp_t_q.size()), 64'd0);
        end
      end
    end
  end

  // Hold cmd_valid until an edge with cmd_ready=1; returns at that edge + 1.
  task automatic wait_hs(input bit noise, output bit ok, output int base, output logic qs);
    bit rdy;
    ok = 1'b0; base = 0; qs = 1'b0;
    for (int w = 0; w < 64 && !ok; w++) begin
      if (noise) abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = (cmd_ready === 1'b1);
      base = cyc;
      qs = q;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    abort = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: cmd_ready not seen within 64 cycles");
    end
  endtask

  // mode 0: valid drops after accept; 1: random garbage offered while busy;
  // 2: valid stays high with the same command (back-to-back).
  task automatic run_cmd(input int cnt, input int gap, input int a, input int mode);
    bit   tl[$];
    bit   ok;
    int   base;
    int   fin_off;
    int   ones;
    int   ab_at;
    logic qs;
    fin_t r;
    for (int i = 1; i <= cnt; i++) begin
      tl.push_back(1'b1);
      if (i < cnt) for (int g = 0; g < gap; g++) tl.push_back(1'b0);
    end
    ab_at = (a > 0 && a <= tl.size()) ? a : 0;
    if (ab_at > 0) while (tl.size() > ab_at) void'(tl.pop_back());
    ones = 0;
    foreach (tl[i]) ones += int'(tl[i]);
    fin_off = tl.size() + 1;
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(cnt);
    cmd_gap   = GAP_W'(gap);
    wait_hs(1'b1, ok, base, qs);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    foreach (tl[i]) exp_t_q.push_back(tl[i]);
    r.ab   = (ab_at > 0);
    r.cnt  = ones;
    r.fcyc = base + fin_off;
    r.qv   = qs ^ ones[0];
    exp_fin_q.push_back(r);
    for (int k = 1; k <= fin_off; k++) begin
      if (k == ab_at)        abort = 1'b1;
      else if (k == fin_off) abort = 1'($urandom_range(0, 1));
      else                   abort = 1'b0;
      if (mode == 1) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_count = CNT_W'($urandom);
        cmd_gap   = GAP_W'($urandom);
      end else if (mode == 0) begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    if (mode != 2) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      abort = 1'b0;
    end
  endtask

  // Reset in cycle k of a command, with abort and cmd_valid also high.
  task automatic reset_mid(input int cnt, input int gap, input int k, input logic expT);
    bit   ok;
    int   base;
    logic qs;
    mon_en = 1'b0;
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(cnt);
    cmd_gap   = GAP_W'(gap);
    wait_hs(1'b0, ok, base, qs);
    cmd_valid = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    chk("pre_reset_T", {63'd0, T}, {63'd0, expT});
    reset = 1'b1; abort = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_T", {63'd0, T}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pulse_cnt", {56'd0, pulse_cnt}, 64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_aborted", {63'd0, aborted}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", {63'd0, done}, 64'd0);
      chk("post_rst_aborted", {63'd0, aborted}, 64'd0);
      chk("post_rst_T", {63'd0, T}, 64'd0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    int cnt, gap, len, a, mode;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_T", {63'd0, T}, 64'd0);
    chk("init_busy", {63'd0, busy}, 64'd0);
    chk("init_done", {63'd0, done}, 64'd0);
    chk("init_aborted", {63'd0, aborted}, 64'd0);
    chk("init_pulse_cnt", {56'd0, pulse_cnt}, 64'd0);
    chk("init_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    run_cmd(3, 0, 0, 0);      // T=1,1,1 then done, Q ends toggled
    run_cmd(2, 2, 0, 0);      // T=1,0,0,1 then done, Q back to start
    run_cmd(0, 3, 0, 0);      // no pulses, done next cycle
    run_cmd(5, 1, 4, 0);      // abort during the second gap
    run_cmd(3, 1, 5, 1);      // abort on the final pulse wins
    run_cmd(4, 0, 2, 1);      // abort mid back-to-back pulses
    reset_mid(4, 0, 2, 1'b1); // reset mid-PULSE
    reset_mid(3, 2, 2, 1'b0); // reset mid-GAP
    run_cmd(2, 1, 0, 2);      // valid held through busy and FIN
    run_cmd(2, 1, 0, 2);
    run_cmd(3, 0, 0, 0);
    run_cmd(255, 0, 0, 0);    // full-width count
    run_cmd(2, 15, 0, 1);     // full-width gap

    for (int n = 0; n < 150; n++) begin
      cnt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 6));
      gap  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      len  = (cnt == 0) ? 0 : cnt + (cnt - 1) * gap;
      a    = (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
      mode = int'($urandom_range(0, 2));
      run_cmd(cnt, gap, a, mode);
    end
    cmd_valid = 1'b0;
    abort = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("leftover_timeline", 64'(exp_t_q.size()), 64'd0);
    chk("leftover_completions", 64'(exp_fin_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
